sound_latch: RTL and testbench
==============================

# sound_latch

Bidirectional mailbox between the main 68000 and the sound 68000 of the Mega System 1 core. It responds to the address-decoder selects for latch0 (main writes, sound reads) and latch1 (sound writes, main reads). It qualifies each access once per bus cycle using the CPU address strobes, and drives the sound CPU's level-4 interrupt request while main-to-sound data is pending.

## Interface
Parameters:
- FIFO_DEPTH, 4: latch0 queue depth when `SOUND_LATCH_FIFO_EN` is defined; must be a power of two, minimum 2. Ignored otherwise.

Ports:
- clk  in  1  system clock. All logic is on the rising edge. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- m68kp_as_n  in  1  main CPU address strobe.
- m68kp_rw  in  1  main CPU read(1)/write(0).
- m68kp_latch0_cs  in  1  main CPU select for latch0 (write side). Combinational and not strobe-gated.
- m68kp_latch1_cs  in  1  main CPU select for latch1 (read side).
- m68kp_dout  in  16  main CPU write data.
- m68kp_latch_din  out  16  latch1 contents presented to the main CPU read mux.
- m68ks_as_n  in  1  sound CPU address strobe.
- m68ks_rw  in  1  sound CPU read/write.
- m68ks_latch0_cs  in  1  sound CPU select for latch0 (read side).
- m68ks_latch1_cs  in  1  sound CPU select for latch1 (write side).
- m68ks_dout  in  16  sound CPU write data.
- m68ks_latch_din  out  16  latch0 head value presented to the sound CPU read mux.
- m68ks_iack  in  1  one-cycle pulse: sound CPU acknowledged IRQ4.
- m68ks_irq4_n  out  1  active-low IRQ4 request to the sound CPU.
- latch0_ovf  out  1  sticky flag: a latch0 write was dropped. Constant 0 without FIFO.

## Operation
- Per-CPU strobe edge detector: as_n is registered each clk.
  - Start = registered as_n 1 and current as_n 0.
  - End = registered as_n 0 and current as_n 1.
- At start, the block captures the cycle kind (which cs, rw) into a per-CPU register. The address may already be changing at end, so end-of-cycle actions use the captured kind.
- Writes commit at start, once per bus cycle. Held strobes or extra wait states never cause a second commit.
  - Main write to latch0 pushes m68kp_dout.
  - Sound write to latch1 loads latch1 with m68ks_dout.
- Reads return the register value during the whole cycle. Side effects apply at end, so data is stable while the CPU samples it.
  - Sound read of latch0 is a pop/acknowledge.
  - Main read of latch1 has no side effect.
- Single-register mode (no FIFO):
  - latch0 write overwrites the register and sets pending.
  - Sound read end clears pending.
- m68ks_irq4_n = !pending. m68ks_iack also clears pending in single-register mode.
- Writes to read-side selects and reads from write-side selects are ignored.

## Timing
- Reset values: latch0 = 0, latch1 = 0, pending = 0, m68ks_irq4_n = 1, FIFO empty, latch0_ovf = 0, both strobe registers = 1, so no spurious start after reset.
- Write latency: the data is visible on the opposite `*_latch_din` and irq4_n falls on the clk after the start cycle.
- Pop latency: the head advances and irq updates on the clk after the end cycle.
- Simultaneous main write start and sound read end on the same clk:
  - Single mode: the write wins and pending stays 1.
  - FIFO mode: push and pop both occur, and a push into a full queue is accepted because a slot frees.
- Reset asserted mid-cycle: all state returns to reset values. A strobe still low after reset deasserts is treated as a new start only after a fresh high-to-low edge.

## Configuration
- `SOUND_LATCH_FIFO_EN` defined: latch0 is a FIFO_DEPTH circular queue with wrapping read/write pointers and a count register.
  - pending = count != 0, so IRQ4 stays low until the queue drains.
  - m68ks_iack has no effect.
  - A push when full (with no simultaneous pop) is dropped and sets latch0_ovf.
  - A pop when empty leaves pointers unchanged, and m68ks_latch_din holds the last popped value.
  - Pointers wrap modulo FIFO_DEPTH.
- Undefined: single 16-bit register with a pending bit, and latch0_ovf is tied to 0.

## Test plan
- Reset, then main writes 0x1234 to latch0 -> irq4_n falls 1 clk after start; m68ks_latch_din = 0x1234; sound read end -> irq4_n = 1 next clk.
- Main write with as_n held low 20 clks, FIFO mode -> exactly one push, count = 1.
- FIFO mode: 5 writes 0x0001..0x0005 with no reads -> latch0_ovf = 1; 4 pops return 0x0001..0x0004; irq4_n rises after the 4th pop; a 5th pop still reads 0x0004.
- Single mode: two writes 0xAAAA then 0x5555 before any read -> read returns 0x5555; m68ks_iack alone clears irq4_n to 1.
- Sound writes 0xBEEF to latch1 -> m68kp_latch_din = 0xBEEF next clk; repeated main reads leave it unchanged.
- Full FIFO with a sound read end coinciding with a main write start -> count stays 4, latch0_ovf stays 0; reset asserted mid-sequence -> all outputs return to reset values.

Source files
------------

// File: rtl/sound_latch.sv
// sound_latch: bidirectional mailbox between the main 68000 and the sound
// 68000. latch0 carries main->sound data and drives the sound CPU's IRQ4
// while data is pending; latch1 carries sound->main data.
//
// Writes commit at the high-to-low edge of the CPU address strobe, once per
// bus cycle. The sound CPU's read of latch0 acts as a pop/acknowledge at the
// low-to-high strobe edge. The pop decision uses the cycle kind captured at
// the start of the cycle, because the address may already be changing when
// the strobe rises.
//
// Build option: define SOUND_LATCH_FIFO_EN to turn latch0 into a FIFO_DEPTH
// circular queue with overflow flag. Without it, latch0 is a single register
// with a pending bit, and latch0_ovf is tied to 0.
//
// Parameters:
//   FIFO_DEPTH       latch0 queue depth (power of two, >= 2), FIFO build only
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   m68kp_as_n/rw    main CPU strobe and read(1)/write(0)
//   m68kp_latch0_cs  main select of latch0 (write side)
//   m68kp_latch1_cs  main select of latch1 (read side)
//   m68kp_dout       main CPU write data
//   m68kp_latch_din  latch1 contents to the main CPU read mux
//   m68ks_as_n/rw    sound CPU strobe and read/write
//   m68ks_latch0_cs  sound select of latch0 (read side)
//   m68ks_latch1_cs  sound select of latch1 (write side)
//   m68ks_dout       sound CPU write data
//   m68ks_latch_din  latch0 head to the sound CPU read mux
//   m68ks_iack       IRQ4 acknowledge pulse (single-register build only)
//   m68ks_irq4_n     active-low IRQ4 to the sound CPU
//   latch0_ovf       sticky: a latch0 write was dropped

module sound_latch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68kp_as_n,
  input  logic        m68kp_rw,
  input  logic        m68kp_latch0_cs,
  input  logic        m68kp_latch1_cs,
  input  logic [15:0] m68kp_dout,
  output logic [15:0] m68kp_latch_din,
  input  logic        m68ks_as_n,
  input  logic        m68ks_rw,
  input  logic        m68ks_latch0_cs,
  input  logic        m68ks_latch1_cs,
  input  logic [15:0] m68ks_dout,
  output logic [15:0] m68ks_latch_din,
  input  logic        m68ks_iack,
  output logic        m68ks_irq4_n,
  output logic        latch0_ovf
);

  logic m_as_q, s_as_q;
  // "armed" means the strobe has been seen high since reset; it keeps a
  // strobe that is still low when reset releases from looking like a start.
  logic m_armed, s_armed;
  logic s_kind_rd0;
  logic m_start, s_start, s_end;
  logic m_push, s_wr1, s_pop;
  logic pending;
  logic [15:0] latch1;

  assign m_start = m_as_q & ~m68kp_as_n & m_armed;
  assign s_start = s_as_q & ~m68ks_as_n & s_armed;
  assign s_end   = ~s_as_q & m68ks_as_n;

  assign m_push = m_start & m68kp_latch0_cs & ~m68kp_rw;
  assign s_wr1  = s_start & m68ks_latch1_cs & ~m68ks_rw;
  assign s_pop  = s_end & s_kind_rd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_as_q     <= 1'b1;
      s_as_q     <= 1'b1;
      m_armed    <= m68kp_as_n;
      s_armed    <= m68ks_as_n;
      s_kind_rd0 <= 1'b0;
      latch1     <= 16'h0000;
    end else begin
      m_as_q  <= m68kp_as_n;
      s_as_q  <= m68ks_as_n;
      m_armed <= m_armed | m68kp_as_n;
      s_armed <= s_armed | m68ks_as_n;
      if (s_start)
        s_kind_rd0 <= m68ks_latch0_cs & m68ks_rw;
      if (s_wr1)
        latch1 <= m68ks_dout;
    end
  end

  assign m68kp_latch_din = latch1;
  assign m68ks_irq4_n    = ~pending;

`ifdef SOUND_LATCH_FIFO_EN

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   last_pop;
  logic          ovf;
  logic          full, empty, pop_ok, push_ok;
  logic          unused_inputs;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign pop_ok  = s_pop & ~empty;
  // A simultaneous pop frees a slot, so a push into a full queue still fits.
  assign push_ok = m_push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_pop <= 16'h0000;
      ovf      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= 16'h0000;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= m68kp_dout;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        last_pop <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (m_push & ~push_ok)
        ovf <= 1'b1;
    end
  end

  // When drained, the sound CPU keeps seeing the value it last popped.
  assign m68ks_latch_din = empty ? last_pop : mem[rd_ptr];
  assign pending         = ~empty;
  assign latch0_ovf      = ovf;
  assign unused_inputs   = m68ks_iack & m68kp_latch1_cs;

`else

  logic [15:0] latch0;
  logic        unused_inputs;

  always_ff @(posedge clk) begin
    if (reset) begin
      latch0  <= 16'h0000;
      pending <= 1'b0;
    end else begin
      if (m_push)
        latch0 <= m68kp_dout;
      // A new write beats a same-clock pop or acknowledge.
      if (m_push)
        pending <= 1'b1;
      else if (s_pop | m68ks_iack)
        pending <= 1'b0;
    end
  end

  assign m68ks_latch_din = latch0;
  assign latch0_ovf      = 1'b0;
  assign unused_inputs   = m68kp_latch1_cs;

`endif

endmodule

// File: tb/tb_sound_latch.sv
module tb_sound_latch;

`ifdef SOUND_LATCH_FIFO_EN
  localparam bit FIFO_MODE = 1'b1;
`else
  localparam bit FIFO_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m68kp_as_n, m68kp_rw, m68kp_latch0_cs, m68kp_latch1_cs;
  logic [15:0] m68kp_dout, m68kp_latch_din;
  logic        m68ks_as_n, m68ks_rw, m68ks_latch0_cs, m68ks_latch1_cs;
  logic [15:0] m68ks_dout, m68ks_latch_din;
  logic        m68ks_iack, m68ks_irq4_n, latch0_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sound_latch #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .m68kp_as_n(m68kp_as_n), .m68kp_rw(m68kp_rw),
    .m68kp_latch0_cs(m68kp_latch0_cs), .m68kp_latch1_cs(m68kp_latch1_cs),
    .m68kp_dout(m68kp_dout), .m68kp_latch_din(m68kp_latch_din),
    .m68ks_as_n(m68ks_as_n), .m68ks_rw(m68ks_rw),
    .m68ks_latch0_cs(m68ks_latch0_cs), .m68ks_latch1_cs(m68ks_latch1_cs),
    .m68ks_dout(m68ks_dout), .m68ks_latch_din(m68ks_latch_din),
    .m68ks_iack(m68ks_iack), .m68ks_irq4_n(m68ks_irq4_n),
    .latch0_ovf(latch0_ovf)
  );

  typedef enum {OP_MW, OP_SR, OP_SW, OP_MR, OP_IACK, OP_MW_L1, OP_SW_L0, OP_SR_L1} op_e;

  typedef struct {
    op_e         op;
    logic [15:0] data;
    logic [15:0] s_single;
    logic        irq_single;
    logic [15:0] s_fifo;
    logic        irq_fifo;
    logic [15:0] p_exp;
  } vec_t;

  vec_t tbl[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    m68kp_as_n = 1'b1; m68kp_rw = 1'b1; m68kp_latch0_cs = 1'b0; m68kp_latch1_cs = 1'b0;
    m68ks_as_n = 1'b1; m68ks_rw = 1'b1; m68ks_latch0_cs = 1'b0; m68ks_latch1_cs = 1'b0;
    m68ks_iack = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic main_cycle(logic cs0, logic cs1, logic rw, logic [15:0] d, int hold);
    m68kp_latch0_cs = cs0; m68kp_latch1_cs = cs1; m68kp_rw = rw; m68kp_dout = d;
    m68kp_as_n = 1'b0;
    repeat (hold) tick();
    m68kp_as_n = 1'b1;
    tick();
    m68kp_latch0_cs = 1'b0; m68kp_latch1_cs = 1'b0; m68kp_rw = 1'b1;
  endtask

  task automatic sound_cycle(logic cs0, logic cs1, logic rw, logic [15:0] d, int hold);
    m68ks_latch0_cs = cs0; m68ks_latch1_cs = cs1; m68ks_rw = rw; m68ks_dout = d;
    m68ks_as_n = 1'b0;
    repeat (hold) tick();
    m68ks_as_n = 1'b1;
    tick();
    m68ks_latch0_cs = 1'b0; m68ks_latch1_cs = 1'b0; m68ks_rw = 1'b1;
  endtask

  task automatic do_op(op_e op, logic [15:0] d);
    case (op)
      OP_MW:    main_cycle(1'b1, 1'b0, 1'b0, d, 2);
      OP_MW_L1: main_cycle(1'b0, 1'b1, 1'b0, d, 2);
      OP_MR:    main_cycle(1'b0, 1'b1, 1'b1, d, 3);
      OP_SR:    sound_cycle(1'b1, 1'b0, 1'b1, d, 2);
      OP_SR_L1: sound_cycle(1'b0, 1'b1, 1'b1, d, 2);
      OP_SW:    sound_cycle(1'b0, 1'b1, 1'b0, d, 2);
      OP_SW_L0: sound_cycle(1'b1, 1'b0, 1'b0, d, 2);
      OP_IACK: begin
        m68ks_iack = 1'b1;
        tick();
        m68ks_iack = 1'b0;
      end
      default: ;
    endcase
    tick();
  endtask

  initial begin
    //            op        data      s_single irq_s  s_fifo   irq_f  p_exp
    tbl[0]  = '{OP_MW,    16'h1234, 16'h1234, 1'b0, 16'h1234, 1'b0, 16'h0000};
    tbl[1]  = '{OP_SR,    16'h0000, 16'h1234, 1'b1, 16'h1234, 1'b1, 16'h0000};
    tbl[2]  = '{OP_MW,    16'hAAAA, 16'hAAAA, 1'b0, 16'hAAAA, 1'b0, 16'h0000};
    tbl[3]  = '{OP_MW,    16'h5555, 16'h5555, 1'b0, 16'hAAAA, 1'b0, 16'h0000};
    tbl[4]  = '{OP_SR,    16'h0000, 16'h5555, 1'b1, 16'h5555, 1'b0, 16'h0000};
    tbl[5]  = '{OP_SR,    16'h0000, 16'h5555, 1'b1, 16'h5555, 1'b1, 16'h0000};
    tbl[6]  = '{OP_MW,    16'h0F0F, 16'h0F0F, 1'b0, 16'h0F0F, 1'b0, 16'h0000};
    tbl[7]  = '{OP_IACK,  16'h0000, 16'h0F0F, 1'b1, 16'h0F0F, 1'b0, 16'h0000};
    tbl[8]  = '{OP_SR,    16'h0000, 16'h0F0F, 1'b1, 16'h0F0F, 1'b1, 16'h0000};
    tbl[9]  = '{OP_SW,    16'hBEEF, 16'h0F0F, 1'b1, 16'h0F0F, 1'b1, 16'hBEEF};
    tbl[10] = '{OP_MR,    16'h0000, 16'h0F0F, 1'b1, 16'h0F0F, 1'b1, 16'hBEEF};
    tbl[11] = '{OP_MR,    16'h0000, 16'h0F0F, 1'b1, 16'h0F0F, 1'b1, 16'hBEEF};
    tbl[12] = '{OP_MW_L1, 16'h1111, 16'h0F0F, 1'b1, 16'h0F0F, 1'b1, 16'hBEEF};
    tbl[13] = '{OP_SW_L0, 16'h2222, 16'h0F0F, 1'b1, 16'h0F0F, 1'b1, 16'hBEEF};
    tbl[14] = '{OP_MW,    16'h3333, 16'h3333, 1'b0, 16'h3333, 1'b0, 16'hBEEF};
    tbl[15] = '{OP_SR_L1, 16'h0000, 16'h3333, 1'b0, 16'h3333, 1'b0, 16'hBEEF};
    tbl[16] = '{OP_SR,    16'h0000, 16'h3333, 1'b1, 16'h3333, 1'b1, 16'hBEEF};
    tbl[17] = '{OP_SW,    16'h7E57, 16'h3333, 1'b1, 16'h3333, 1'b1, 16'h7E57};

    m68kp_dout = 16'h0000;
    m68ks_dout = 16'h0000;
    do_reset();

    // Reset state and write/pop latency.
    check("rst_irq4_n", {15'b0, m68ks_irq4_n}, 16'h0001);
    check("rst_s_din", m68ks_latch_din, 16'h0000);
    check("rst_p_din", m68kp_latch_din, 16'h0000);
    check("rst_ovf", {15'b0, latch0_ovf}, 16'h0000);

    m68kp_latch0_cs = 1'b1; m68kp_rw = 1'b0; m68kp_dout = 16'h1234; m68kp_as_n = 1'b0;
    check("lat_irq_before_start", {15'b0, m68ks_irq4_n}, 16'h0001);
    tick();
    check("lat_irq_after_start", {15'b0, m68ks_irq4_n}, 16'h0000);
    check("lat_s_din", m68ks_latch_din, 16'h1234);
    tick();
    m68kp_as_n = 1'b1;
    tick();
    idle_bus();
    m68ks_latch0_cs = 1'b1; m68ks_rw = 1'b1; m68ks_as_n = 1'b0;
    tick();
    tick();
    check("lat_read_data_stable", m68ks_latch_din, 16'h1234);
    m68ks_as_n = 1'b1;
    check("lat_irq_before_end", {15'b0, m68ks_irq4_n}, 16'h0000);
    tick();
    check("lat_irq_after_end", {15'b0, m68ks_irq4_n}, 16'h0001);
    idle_bus();
    tick();

    // Table-driven operations from a clean reset.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      do_op(tbl[i].op, tbl[i].data);
      check($sformatf("vec%0d_s_din", i), m68ks_latch_din,
            FIFO_MODE ? tbl[i].s_fifo : tbl[i].s_single);
      check($sformatf("vec%0d_irq4_n", i), {15'b0, m68ks_irq4_n},
            {15'b0, FIFO_MODE ? tbl[i].irq_fifo : tbl[i].irq_single});
      check($sformatf("vec%0d_p_din", i), m68kp_latch_din, tbl[i].p_exp);
    end

    // Strobe held low for 20 clks with changing data: exactly one commit.
    do_reset();
    m68kp_latch0_cs = 1'b1; m68kp_rw = 1'b0; m68kp_dout = 16'h4444; m68kp_as_n = 1'b0;
    tick();
    m68kp_dout = 16'h9999;
    repeat (19) tick();
    m68kp_as_n = 1'b1;
    tick();
    idle_bus();
    tick();
    check("hold_s_din", m68ks_latch_din, 16'h4444);
    check("hold_irq", {15'b0, m68ks_irq4_n}, 16'h0000);
    do_op(OP_SR, 16'h0);
    check("hold_pop1_irq", {15'b0, m68ks_irq4_n}, 16'h0001);
    do_op(OP_SR, 16'h0);
    check("hold_pop2_irq", {15'b0, m68ks_irq4_n}, 16'h0001);
    check("hold_pop2_s_din", m68ks_latch_din, 16'h4444);

    // Five writes with no reads.
    do_reset();
    for (int i = 1; i <= 5; i++) do_op(OP_MW, 16'(i));
    check("ovf_flag", {15'b0, latch0_ovf}, FIFO_MODE ? 16'h0001 : 16'h0000);
    if (FIFO_MODE) begin
      for (int i = 1; i <= 4; i++) begin
        check($sformatf("ovf_head%0d", i), m68ks_latch_din, 16'(i));
        do_op(OP_SR, 16'h0);
        check($sformatf("ovf_irq_pop%0d", i), {15'b0, m68ks_irq4_n},
              (i == 4) ? 16'h0001 : 16'h0000);
      end
      do_op(OP_SR, 16'h0);
      check("ovf_pop5_s_din", m68ks_latch_din, 16'h0004);
      check("ovf_pop5_irq", {15'b0, m68ks_irq4_n}, 16'h0001);
    end else begin
      check("single_last_write", m68ks_latch_din, 16'h0005);
      do_op(OP_SR, 16'h0);
      check("single_pop_irq", {15'b0, m68ks_irq4_n}, 16'h0001);
    end

    // Main write start coinciding with sound read end.
    do_reset();
    for (int i = 0; i < (FIFO_MODE ? 4 : 1); i++) do_op(OP_MW, 16'h0010 + 16'(i));
    m68ks_latch0_cs = 1'b1; m68ks_rw = 1'b1; m68ks_as_n = 1'b0;
    tick();
    tick();
    m68kp_latch0_cs = 1'b1; m68kp_rw = 1'b0; m68kp_dout = 16'h0020; m68kp_as_n = 1'b0;
    m68ks_as_n = 1'b1;
    tick();
    m68kp_as_n = 1'b1;
    tick();
    idle_bus();
    tick();
    check("coin_ovf", {15'b0, latch0_ovf}, 16'h0000);
    check("coin_irq", {15'b0, m68ks_irq4_n}, 16'h0000);
    if (FIFO_MODE) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("coin_head%0d", i), m68ks_latch_din,
              (i == 3) ? 16'h0020 : 16'h0011 + 16'(i));
        do_op(OP_SR, 16'h0);
        check($sformatf("coin_irq_pop%0d", i), {15'b0, m68ks_irq4_n},
              (i == 3) ? 16'h0001 : 16'h0000);
      end
    end else begin
      check("coin_s_din", m68ks_latch_din, 16'h0020);
      do_op(OP_SR, 16'h0);
      check("coin_pop_irq", {15'b0, m68ks_irq4_n}, 16'h0001);
    end

    // Reset asserted mid-cycle with both strobes still low afterwards.
    do_reset();
    m68kp_latch0_cs = 1'b1; m68kp_rw = 1'b0; m68kp_dout = 16'h7777; m68kp_as_n = 1'b0;
    m68ks_latch1_cs = 1'b1; m68ks_rw = 1'b0; m68ks_dout = 16'hCAFE; m68ks_as_n = 1'b0;
    tick();
    check("mid_pre_p_din", m68kp_latch_din, 16'hCAFE);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_irq", {15'b0, m68ks_irq4_n}, 16'h0001);
    check("mid_rst_s_din", m68ks_latch_din, 16'h0000);
    check("mid_rst_p_din", m68kp_latch_din, 16'h0000);
    check("mid_rst_ovf", {15'b0, latch0_ovf}, 16'h0000);
    repeat (3) tick();
    check("mid_held_irq", {15'b0, m68ks_irq4_n}, 16'h0001);
    check("mid_held_p_din", m68kp_latch_din, 16'h0000);
    m68kp_as_n = 1'b1; m68ks_as_n = 1'b1;
    tick();
    m68kp_dout = 16'h5A5A; m68kp_as_n = 1'b0; m68ks_as_n = 1'b0;
    tick();
    check("mid_fresh_s_din", m68ks_latch_din, 16'h5A5A);
    check("mid_fresh_irq", {15'b0, m68ks_irq4_n}, 16'h0000);
    check("mid_fresh_p_din", m68kp_latch_din, 16'hCAFE);
    idle_bus();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
